fc_layer_sequencer: RTL and testbench

// Sequences one fully-connected layer pass over the shared 16-bit word memory: streams the input vector,

---
 rtl/fc_layer_sequencer.sv | 156 +++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Sequencer for one fully-connected layer pass: loads operands from word memory into the fc_layer
// buffers, runs the layer until it reports finished, then writes the outputs back to memory.
//
// state | meaning
// IDLE  | waiting for start
// LD_IN | reading input vector, one word per cycle
// LD_W  | reading weight matrix, one word per cycle
// LD_B  | reading bias vector, one word per cycle
// DRAIN | no read; last bias word is delivered to the layer
// RUN   | layer enabled, waiting for layer_finished
// WB    | writing layer outputs back to memory, one word per cycle
// DONE  | one-cycle completion pulse
module fc_layer_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 14,
    parameter int N_IN     = 120,
    parameter int N_OUT    = 84,
    parameter int IN_BASE  = 0,
    parameter int W_BASE   = 120,
    parameter int B_BASE   = 10200,
    parameter int OUT_BASE = 10284
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              load_valid,
    output logic [1:0]        load_sel,
    output logic [15:0]       load_idx,
    output logic [DATA_W-1:0] load_data,
    output logic              layer_enable,
    input  logic              layer_finished,
    output logic [15:0]       out_rd_idx,
    input  logic [DATA_W-1:0] out_rd_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LD_IN = 3'd1;
    localparam logic [2:0] S_LD_W  = 3'd2;
    localparam logic [2:0] S_LD_B  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_RUN   = 3'd5;
    localparam logic [2:0] S_WB    = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [31:0] LAST_IN  = 32'(N_IN) - 32'd1;
    localparam logic [31:0] LAST_W   = 32'(N_IN * N_OUT) - 32'd1;
    localparam logic [31:0] LAST_OUT = 32'(N_OUT) - 32'd1;

    logic [2:0]        state;
    logic [31:0]       k;
    logic              reading;
    logic              writing;
    logic [1:0]        rd_sel;
    logic [ADDR_W-1:0] base;
    logic [31:0]       last_k;
    logic              k_last;

    // Phase decode: which buffer is being filled, its base address and its final index.
    always_comb begin
        reading = 1'b0;
        rd_sel  = 2'd0;
        base    = '0;
        last_k  = '0;
        case (state)
            S_LD_IN: begin
                reading = 1'b1;
                rd_sel  = 2'd0;
                base    = ADDR_W'(IN_BASE);
                last_k  = LAST_IN;
            end
            S_LD_W: begin
                reading = 1'b1;
                rd_sel  = 2'd1;
                base    = ADDR_W'(W_BASE);
                last_k  = LAST_W;
            end
            S_LD_B: begin
                reading = 1'b1;
                rd_sel  = 2'd2;
                base    = ADDR_W'(B_BASE);
                last_k  = LAST_OUT;
            end
            S_WB: begin
                base    = ADDR_W'(OUT_BASE);
                last_k  = LAST_OUT;
            end
            default: ;
        endcase
    end

    assign writing    = (state == S_WB);
    assign k_last     = (k == last_k);
    assign mem_rd_en  = reading;
    assign mem_wr_en  = writing;
    assign mem_addr   = (reading || writing) ? base + k[ADDR_W-1:0] : '0;
    assign mem_wdata  = writing ? out_rd_data : '0;
    assign out_rd_idx = writing ? k[15:0] : '0;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign load_data  = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            k            <= '0;
            load_valid   <= 1'b0;
            load_sel     <= 2'd0;
            load_idx     <= '0;
            layer_enable <= 1'b0;
        end else begin
            // Tags trail the read by one cycle so they line up with mem_rdata.
            load_valid <= reading;
            load_sel   <= reading ? rd_sel : 2'd0;
            load_idx   <= reading ? k[15:0] : 16'd0;
            case (state)
                S_IDLE: begin
                    k <= '0;
                    if (start) state <= S_LD_IN;
                end
                S_LD_IN, S_LD_W, S_LD_B, S_WB: begin
                    if (k_last) begin
                        k <= '0;
                        case (state)
                            S_LD_IN: state <= S_LD_W;
                            S_LD_W:  state <= S_LD_B;
                            S_LD_B:  state <= S_DRAIN;
                            default: state <= S_DONE;
                        endcase
                    end else begin
                        k <= k + 32'd1;
                    end
                end
                S_DRAIN: begin
                    layer_enable <= 1'b1;
                    state        <= S_RUN;
                end
                S_RUN: begin
                    if (layer_finished && layer_enable) begin
                        layer_enable <= 1'b0;
                        k            <= '0;
                        state        <= S_WB;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer on a tiny 3->2 layer: memory and fc_layer are modelled here and every
// cycle of a pass is compared against the read/load/write schedule derived from the layer geometry.
module tb_fc_layer_sequencer;
    localparam int DW = 16;
    localparam int AW = 14;
    localparam int NI = 3;
    localparam int NO = 2;
    localparam int IB = 0;
    localparam int WBASE = 3;
    localparam int BB = 9;
    localparam int OB = 11;
    localparam int NREAD = NI + NI * NO + NO;

    logic          clk = 1'b0;
    logic          reset, start, busy, done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en, mem_wr_en;
    logic [DW-1:0] mem_wdata, mem_rdata, load_data, out_rd_data;
    logic          load_valid, layer_enable, layer_finished;
    logic [1:0]    load_sel;
    logic [15:0]   load_idx, out_rd_idx;
    logic [15:0]   out_val_base;

    logic [15:0]   src_mem [0:(1<<AW)-1];
    logic [15:0]   res_mem [0:(1<<AW)-1];
    int            wr_count = 0;
    int            done_cnt = 0;
    int            n_pass = 0;
    int            n_total = 0;

    fc_layer_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .N_IN(NI), .N_OUT(NO),
        .IN_BASE(IB), .W_BASE(WBASE), .B_BASE(BB), .OUT_BASE(OB)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .load_valid(load_valid), .load_sel(load_sel), .load_idx(load_idx), .load_data(load_data),
        .layer_enable(layer_enable), .layer_finished(layer_finished),
        .out_rd_idx(out_rd_idx), .out_rd_data(out_rd_data)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency; writes land in a separate result array.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= src_mem[mem_addr];
        if (mem_wr_en) begin
            res_mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    assign out_rd_data = out_val_base + out_rd_idx;

    // Reference schedule: the r-th read of a pass, from the layer geometry.
    function automatic int ref_sel(int r);
        if (r < NI) return 0;
        if (r < NI + NI * NO) return 1;
        return 2;
    endfunction

    function automatic int ref_idx(int r);
        if (r < NI) return r;
        if (r < NI + NI * NO) return r - NI;
        return r - NI - NI * NO;
    endfunction

    function automatic int ref_addr(int r);
        int bases [3];
        bases = '{IB, WBASE, BB};
        return bases[ref_sel(r)] + ref_idx(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NREAD; i++) src_mem[i] = 16'($urandom);
        out_val_base = 16'($urandom_range(0, 16'hFF00));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, "_wr_en"}, 32'(mem_wr_en), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_lvalid"}, 32'(load_valid), 0);
        chk({tag, "_lsel"}, 32'(load_sel), 0);
        chk({tag, "_lidx"}, 32'(load_idx), 0);
        chk({tag, "_len"}, 32'(layer_enable), 0);
        chk({tag, "_oidx"}, 32'(out_rd_idx), 0);
    endtask

    // One complete pass starting from an IDLE negedge; returns at the IDLE negedge afterwards.
    task automatic run_pass(input int fin_delay, input bit hold_start, input bit fin_in_ld,
                            input bit poke);
        int w0;
        w0 = wr_count;
        start = 1'b1;
        layer_finished = fin_in_ld;
        for (int c = 1; c <= NREAD + 1; c++) begin
            cyc();
            if (!hold_start) start = (poke && c == 5);
            layer_finished = fin_in_ld && (c < 3);
            chk("ld_busy", 32'(busy), 1);
            chk("ld_done", 32'(done), 0);
            chk("ld_len", 32'(layer_enable), 0);
            chk("ld_wr_en", 32'(mem_wr_en), 0);
            chk("ld_rd_en", 32'(mem_rd_en), (c <= NREAD) ? 1 : 0);
            if (c <= NREAD) chk("ld_addr", 32'(mem_addr), ref_addr(c - 1));
            chk("ld_lvalid", 32'(load_valid), (c >= 2) ? 1 : 0);
            if (c >= 2) begin
                chk("ld_lsel", 32'(load_sel), ref_sel(c - 2));
                chk("ld_lidx", 32'(load_idx), ref_idx(c - 2));
                chk("ld_ldata", 32'(load_data), 32'(src_mem[ref_addr(c - 2)]));
            end
        end
        cyc();
        chk("run_entry_len", 32'(layer_enable), 1);
        chk("run_entry_rd_en", 32'(mem_rd_en), 0);
        chk("run_entry_lvalid", 32'(load_valid), 0);
        for (int w = 1; w < fin_delay; w++) begin
            cyc();
            chk("run_wait_len", 32'(layer_enable), 1);
            chk("run_wait_busy", 32'(busy), 1);
        end
        layer_finished = 1'b1;
        for (int o = 0; o < NO; o++) begin
            cyc();
            layer_finished = 1'b0;
            chk("wb_len", 32'(layer_enable), 0);
            chk("wb_wr_en", 32'(mem_wr_en), 1);
            chk("wb_rd_en", 32'(mem_rd_en), 0);
            chk("wb_addr", 32'(mem_addr), OB + o);
            chk("wb_oidx", 32'(out_rd_idx), o);
            chk("wb_wdata", 32'(mem_wdata), 32'(16'(out_val_base + 16'(o))));
            chk("wb_done", 32'(done), 0);
        end
        cyc();
        if (poke) start = 1'b1;
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_wr_en", 32'(mem_wr_en), 0);
        cyc();
        if (poke) start = 1'b0;
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("wr_count", 32'(wr_count - w0), NO);
        for (int o = 0; o < NO; o++)
            chk("result_mem", 32'(res_mem[OB + o]), 32'(16'(out_val_base + 16'(o))));
        if (poke) begin
            cyc();
            chk("poke_no_restart", 32'(busy), 0);
        end
    endtask

    initial begin
        int w0;
        reset = 1'b1;
        start = 1'b0;
        layer_finished = 1'b0;
        out_val_base = 16'h0000;
        for (int i = 0; i < NREAD; i++) src_mem[i] = 16'(i + 1);
        @(negedge clk);
        cyc();
        check_all_zero("reset");
        reset = 1'b0;
        cyc();
        chk("idle_busy0", 32'(busy), 0);

        // Directed memory contents 1..11, outputs 0x00AA+idx, finished 5 cycles into RUN.
        out_val_base = 16'h00AA;
        run_pass(5, 1'b0, 1'b0, 1'b0);

        // start pulses during LD_W and DONE are ignored.
        fill_random();
        run_pass(3, 1'b0, 1'b0, 1'b1);

        // Reset in LD_W at k=2 abandons the pass without any write.
        fill_random();
        w0 = wr_count;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 2; c <= NI + 3; c++) cyc();
        chk("abort_addr", 32'(mem_addr), WBASE + 2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_all_zero("abort");
        chk("abort_no_write", 32'(wr_count - w0), 0);
        run_pass(2, 1'b0, 1'b0, 1'b0);

        // layer_finished held during LD_IN has no effect.
        fill_random();
        run_pass(4, 1'b0, 1'b1, 1'b0);

        // start held high: back-to-back passes with one IDLE cycle between.
        fill_random();
        run_pass(2, 1'b1, 1'b0, 1'b0);
        fill_random();
        run_pass(1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("final_idle", 32'(busy), 0);
        chk("done_pulses", 32'(done_cnt), 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
